// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 64 x 72-bit datapath register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 72;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEPTH              = 1 << DEFAULT_ADDR_WIDTH;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

    // Value an entry holds after reset: its own index, zero-extended.
    function automatic reg_data_t reset_value(input int unsigned idx);
        return reg_data_t'(idx);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: captures either the stored entry or the forwarded write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] entry_data,
    input  logic                  bypass_hit,
    input  logic [DATA_WIDTH-1:0] bypass_data,
    output logic [DATA_WIDTH-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out <= '0;
        end else begin
            data_out <= bypass_hit ? bypass_data : entry_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file; entries reset to their own index.
// REGISTER_WRITE_BYPASS_EN selects write-first forwarding; default is read-first.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg1_address,
    input  logic [ADDR_WIDTH-1:0] reg2_address,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic                  hit1;
    logic                  hit2;

    // Reset dominates, so a write presented in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
        end else if (write_enable) begin
            mem[write_address] <= data_in;
        end
    end

`ifdef REGISTER_WRITE_BYPASS_EN
    assign hit1 = write_enable && (write_address == reg1_address);
    assign hit2 = write_enable && (write_address == reg2_address);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_read_port1 (
        .clk         (clk),
        .reset       (reset),
        .entry_data  (mem[reg1_address]),
        .bypass_hit  (hit1),
        .bypass_data (data_in),
        .data_out    (data_out1)
    );

    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_read_port2 (
        .clk         (clk),
        .reset       (reset),
        .entry_data  (mem[reg2_address]),
        .bypass_hit  (hit2),
        .bypass_data (data_in),
        .data_out    (data_out2)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed plan followed by randomized traffic.
module tb_register_file;
    import regfile_pkg::*;

`ifdef REGISTER_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    reg_addr_t reg1_address = '0;
    reg_addr_t reg2_address = '0;
    logic      write_enable = 1'b0;
    reg_addr_t write_address = '0;
    reg_data_t data_in = '0;
    reg_data_t data_out1;
    reg_data_t data_out2;

    register_file dut (
        .clk           (clk),
        .reset         (reset),
        .reg1_address  (reg1_address),
        .reg2_address  (reg2_address),
        .write_enable  (write_enable),
        .write_address (write_address),
        .data_in       (data_in),
        .data_out1     (data_out1),
        .data_out2     (data_out2)
    );

    always #5 clk = ~clk;

    typedef struct {
        reg_data_t e1;
        reg_data_t e2;
        string     name;
    } exp_t;

    exp_t      sb[$];
    reg_data_t model [DEPTH];
    int        checks = 0;
    int        failures = 0;

    localparam reg_data_t ONES = {DEFAULT_DATA_WIDTH{1'b1}};

    // One clock of stimulus; the expected port values follow directly from the behavioural rules.
    task automatic cycle(input bit rst, input int a1, input int a2, input bit we,
                         input int wa, input reg_data_t din, input string name);
        exp_t x;
        @(negedge clk);
        reset         = rst;
        reg1_address  = reg_addr_t'(a1);
        reg2_address  = reg_addr_t'(a2);
        write_enable  = we;
        write_address = reg_addr_t'(wa);
        data_in       = din;
        if (!rst) begin
            x.e1 = '0;
            x.e2 = '0;
            for (int i = 0; i < DEPTH; i++) model[i] = reg_data_t'(i);
        end else begin
            x.e1 = (BYPASS && we && wa == a1) ? din : model[a1];
            x.e2 = (BYPASS && we && wa == a2) ? din : model[a2];
            if (we) model[wa] = din;
        end
        x.name = name;
        sb.push_back(x);
    endtask

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (data_out1 !== x.e1 || data_out2 !== x.e2) begin
                failures++;
                $display("FAIL %s: got out1=%h out2=%h, expected out1=%h out2=%h",
                         x.name, data_out1, data_out2, x.e1, x.e2);
            end
        end
    end

    initial begin
        reg_data_t rd;
        int        a1;
        int        a2;
        int        wa;

        cycle(1'b0, 0, 1, 1'b0, 0, '0, "reset_a");
        cycle(1'b0, 0, 1, 1'b1, 3, 72'h99, "reset_b");
        cycle(1'b1, 0, 1, 1'b0, 0, '0, "read_0_1");
        for (int p = 2; p <= 8; p += 2) cycle(1'b1, p, p + 1, 1'b0, 0, '0, "sweep_pair");
        cycle(1'b1, 3, 3, 1'b0, 0, '0, "reset_write_ignored");

        cycle(1'b1, 4, 4, 1'b1, 5, 72'hABCDEF0123456789AB, "write5_cycle");
        cycle(1'b1, 5, 5, 1'b0, 0, '0, "read_5_5");
        cycle(1'b1, 4, 5, 1'b0, 0, '0, "read_4_5");

        cycle(1'b1, 7, 6, 1'b1, 7, 72'h123, "same_cycle_7_6");
        cycle(1'b1, 7, 6, 1'b0, 0, '0, "after_write_7_6");

        cycle(1'b1, 9, 9, 1'b1, 10, 72'hFFF, "write10");
        cycle(1'b1, 10, 10, 1'b0, 0, '0, "read10_fff");
        cycle(1'b0, 10, 10, 1'b1, 10, 72'h55, "reset_with_write");
        cycle(1'b1, 10, 10, 1'b0, 0, '0, "read10_after_reset");

        cycle(1'b1, 1, 2, 1'b1, 63, ONES, "write63_ones");
        cycle(1'b1, 1, 2, 1'b1, 0, ONES, "write0_ones");
        cycle(1'b1, 63, 0, 1'b0, 0, '0, "read_63_0");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                a1 = $urandom_range(0, 3);
                a2 = $urandom_range(0, 3);
                wa = $urandom_range(0, 3);
            end else begin
                a1 = $urandom_range(0, DEPTH - 1);
                a2 = $urandom_range(0, DEPTH - 1);
                wa = $urandom_range(0, DEPTH - 1);
            end
            rd = {8'($urandom), 32'($urandom), 32'($urandom)};
            cycle(($urandom_range(0, 49) != 0), a1, a2, ($urandom_range(0, 1) == 1), wa, rd, "random");
        end

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
